// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: queues change codes (change) in a FIFO and pays them out coin by coin over a coin_req/coin_sel/coin_ack ejector handshake; reports busy, sticky overflow/fault (cleared by clr_flags), paid_total and saturating vend_count
module vend_change_dispenser #(
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [1:0] change,
  input  logic       clr_flags,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic       coin_sel,
  output logic       busy,
  output logic       overflow,
  output logic       fault,
  output logic [7:0] paid_total,
  output logic [7:0] vend_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ACK, GAP} state_t;
  state_t state;
  logic [1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] pending;
  logic [TW-1:0] tmr;
  logic pop, accept, drop, ack, tmo;
  assign pop = state == LOAD;
  assign accept = |change && (count != (AW+1)'(FIFO_DEPTH) || pop);
  assign drop = |change && !accept;
  assign ack = state == WAIT_ACK && coin_ack;
  assign tmo = state == WAIT_ACK && !coin_ack && tmr == TW'(ACK_TIMEOUT - 1);
  assign busy = |count || state != IDLE;
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= change;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pending <= '0;
      tmr <= '0;
      coin_req <= 1'b0;
      coin_sel <= 1'b0;
      overflow <= 1'b0;
      fault <= 1'b0;
      paid_total <= '0;
      vend_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
      overflow <= drop || (overflow && !clr_flags);
      fault <= tmo || (fault && !clr_flags);
      if (vend && vend_count != 8'hff) vend_count <= vend_count + 1'b1;
      case (state)
        IDLE: if (|count) state <= LOAD;
        LOAD: begin
          pending <= mem[rd_ptr];
          state <= ISSUE;
        end
        ISSUE: begin
          coin_req <= 1'b1;
          coin_sel <= pending[1];
          tmr <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK:
          if (ack) begin
            pending <= coin_sel ? {1'b0, pending[0]} : {pending[1], 1'b0};
            paid_total <= paid_total + (coin_sel ? 8'd10 : 8'd5);
            coin_req <= 1'b0;
            state <= GAP;
          end else if (tmo) begin
            pending <= '0;
            coin_req <= 1'b0;
            state <= GAP;
          end else tmr <= tmr + 1'b1;
        GAP: state <= |pending ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vend_change_dispenser.sv
// tb_vend_change_dispenser: scenario tasks plus randomized bursts checked against a transaction-level coin/payout model
module tb_vend_change_dispenser;
  logic clk = 0, rst = 1, vend = 0, clr_flags = 0, coin_ack = 0;
  logic [1:0] change = 0;
  logic coin_req, coin_sel, busy, overflow, fault;
  logic [7:0] paid_total, vend_count;
  int checks = 0, errors = 0;
  int ack_dly = 0, wait_n = 0, req_cycles = 0, low_run = 0;
  logic prev_req = 0;
  logic obs[$];
  int gaps[$];

  vend_change_dispenser #(.FIFO_DEPTH(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .vend(vend), .change(change), .clr_flags(clr_flags),
    .coin_ack(coin_ack), .coin_req(coin_req), .coin_sel(coin_sel), .busy(busy),
    .overflow(overflow), .fault(fault), .paid_total(paid_total), .vend_count(vend_count)
  );

  always #5 clk = ~clk;

  // ejector: ack_dly >= 0 acks that many cycles after a request rises, -1 never acks, -2 holds ack high
  initial forever begin
    @(posedge clk);
    #1;
    if (coin_req && !prev_req) begin
      obs.push_back(coin_sel);
      gaps.push_back(low_run);
      wait_n = 0;
    end
    low_run = coin_req ? 0 : low_run + 1;
    if (coin_req) req_cycles++;
    coin_ack = ack_dly == -2 || (coin_req && ack_dly >= 0 && wait_n >= ack_dly);
    if (coin_req) wait_n++;
    prev_req = coin_req;
  end

  task automatic do_reset();
    rst = 1; change = 0; vend = 0; clr_flags = 0; ack_dly = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    obs.delete(); gaps.delete(); req_cycles = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, lim); end
  endtask

  task automatic test_reset();
    rst = 1;
    #2;
    do_reset();
    #1;
    checks++; if (coin_req !== 1'b0) begin errors++; $display("FAIL reset_coin_req: got %b, required 0", coin_req); end
    checks++; if (coin_sel !== 1'b0) begin errors++; $display("FAIL reset_coin_sel: got %b, required 0", coin_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (overflow !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b, required 00", overflow, fault); end
    checks++; if (paid_total !== 8'd0 || vend_count !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d, required 0/0", paid_total, vend_count); end
  endtask

  task automatic test_change11();
    do_reset();
    ack_dly = 1;
    @(negedge clk); change = 2'b11;
    @(posedge clk); #1; change = 0;
    checks++; if (busy !== 1'b1 || coin_req !== 1'b0) begin errors++; $display("FAIL c11_edgeN: busy/req got %b%b, required 10", busy, coin_req); end
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (coin_req !== 1'b0) begin errors++; $display("FAIL c11_early_req: got %b, required 0", coin_req); end
    end
    @(posedge clk); #1;
    checks++; if (coin_req !== 1'b1 || coin_sel !== 1'b1) begin errors++; $display("FAIL c11_latency: req/sel got %b%b, required 11", coin_req, coin_sel); end
    wait_idle(50);
    checks++; if (obs.size() != 2 || obs[0] !== 1'b1 || obs[1] !== 1'b0) begin errors++; $display("FAIL c11_order: got %0d coins, required 10-unit then 5-unit", obs.size()); end
    // request low spans the GAP cycle plus the ISSUE cycle that re-registers coin_req
    checks++; if (gaps.size() != 2 || gaps[1] != 2) begin errors++; $display("FAIL c11_gap: got %0d low cycles, required 2", gaps.size() == 2 ? gaps[1] : -1); end
    checks++; if (paid_total !== 8'd15) begin errors++; $display("FAIL c11_paid: got %0d, required 15", paid_total); end
  endtask

  task automatic test_overflow();
    do_reset();
    ack_dly = -1;
    @(negedge clk); change = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, required 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
    @(negedge clk); change = 0; clr_flags = 1;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
    @(negedge clk); change = 2'b01; clr_flags = 1;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clear: got %b, required 1", overflow); end
    @(negedge clk); change = 0; clr_flags = 0; ack_dly = 0;
    wait_idle(200);
    checks++; if (obs.size() != 5 || paid_total !== 8'd25) begin errors++; $display("FAIL ovf_drain: got %0d coins paid %0d, required 5 coins paid 25", obs.size(), paid_total); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ovf_fault: got %b, required 0", fault); end
  endtask

  task automatic test_timeout();
    do_reset();
    ack_dly = -1;
    @(negedge clk); change = 2'b10;
    @(posedge clk); #1; change = 0;
    wait_idle(60);
    checks++; if (req_cycles != 15) begin errors++; $display("FAIL tmo_req_cycles: got %0d, required 15", req_cycles); end
    checks++; if (fault !== 1'b1 || coin_req !== 1'b0) begin errors++; $display("FAIL tmo_fault: fault/req got %b%b, required 10", fault, coin_req); end
    checks++; if (paid_total !== 8'd0) begin errors++; $display("FAIL tmo_paid: got %0d, required 0", paid_total); end
    @(negedge clk); clr_flags = 1;
    @(posedge clk); #1; clr_flags = 0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b, required 0", fault); end
  endtask

  task automatic test_vend_wrap();
    do_reset();
    @(negedge clk); vend = 1;
    repeat (254) @(posedge clk);
    #1;
    checks++; if (vend_count !== 8'd254) begin errors++; $display("FAIL vend_254: got %0d, required 254", vend_count); end
    repeat (6) @(posedge clk);
    #1; vend = 0;
    checks++; if (vend_count !== 8'd255) begin errors++; $display("FAIL vend_sat: got %0d, required 255", vend_count); end
    ack_dly = 0;
    repeat (26) begin
      @(negedge clk); change = 2'b10;
      @(posedge clk); #1; change = 0;
      wait_idle(30);
    end
    checks++; if (paid_total !== 8'((26 * 10) % 256)) begin errors++; $display("FAIL paid_wrap: got %0d, required %0d", paid_total, (26 * 10) % 256); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_dly = -1;
    @(negedge clk); change = 2'b10;
    repeat (3) @(posedge clk);
    #1; change = 0;
    for (int n = 0; n < 10 && !coin_req; n++) begin
      @(posedge clk); #1;
    end
    checks++; if (coin_req !== 1'b1) begin errors++; $display("FAIL rmid_req_rise: got %b, required 1", coin_req); end
    @(posedge clk); #3; rst = 1;
    #1;
    checks++; if (coin_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_async: req/busy got %b%b, required 00", coin_req, busy); end
    @(posedge clk);
    @(negedge clk); rst = 0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (obs.size() != 1 || paid_total !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_abandon: got %0d coins paid %0d busy %b, required 1 coin paid 0 busy 0", obs.size(), paid_total, busy); end
  endtask

  task automatic test_random();
    logic exp[$];
    int paid = 0;
    logic [1:0] code;
    do_reset();
    repeat (30) begin
      int n;
      n = int'($urandom_range(1, 4));
      ack_dly = int'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) ack_dly = -2;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        code = 2'($urandom_range(1, 3));
        change = code;
        if (code[1]) begin exp.push_back(1'b1); paid += 10; end
        if (code[0]) begin exp.push_back(1'b0); paid += 5; end
      end
      @(negedge clk); change = 0;
      wait_idle(300);
    end
    checks++; if (obs.size() != exp.size()) begin errors++; $display("FAIL rnd_count: got %0d coins, required %0d", obs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp[i]) begin errors++; $display("FAIL rnd_coin[%0d]: got sel %b, required %b", i, obs[i], exp[i]); end
    end
    checks++; if (paid_total !== 8'(paid % 256)) begin errors++; $display("FAIL rnd_paid: got %0d, required %0d", paid_total, paid % 256); end
    checks++; if (overflow !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rnd_flags: got %b%b, required 00", overflow, fault); end
  endtask

  initial begin
    test_reset();
    test_change11();
    test_overflow();
    test_timeout();
    test_vend_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
